ctrl_unit: RTL and testbench
============================

CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max cycles a memory wait lasts before abort (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port I_CLK  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port I_RST  input  1  synchronous active-high reset.
REQ-006 SHALL have port I_MEM_RDY  input  1  memory handshake ready (fetch or data access complete).
REQ-007 SHALL have port I_IS_MEM  input  1  decoded instruction needs a memory stage; sampled in ALU.
REQ-008 SHALL have port I_IS_WB  input  1  decoded instruction writes the register file; sampled in ALU and MEMORY.
REQ-009 SHALL have port I_HALT  input  1  hold in FETCH without issuing requests.
REQ-010 SHALL have port O_STATE  output  6  one-hot state: bit0 FETCH, bit1 DECODE, bit2 REGREAD, bit3 ALU, bit4 MEMORY, bit5 REGWRITE.
REQ-011 SHALL have port O_RF_EN  output  1  register-file enable.
REQ-012 SHALL have port O_RF_WE  output  1  register-file write enable.
REQ-013 SHALL have port O_MEM_REQ  output  1  memory request.
REQ-014 SHALL have port O_PC_INC  output  1  one-cycle program-counter advance pulse.
REQ-015 SHALL have port O_ERR  output  1  sticky memory-timeout flag.
REQ-016 SHALL have port O_INSTR_CNT  output  CNT_W  retired-instruction count.

Function
REQ-017 SHALL implement FSM FETCH, DECODE, REGREAD, ALU, MEMORY, REGWRITE; exactly one O_STATE bit high every cycle.
REQ-018 FETCH: I_HALT=1 -> stay, O_MEM_REQ=0; else O_MEM_REQ=1; I_MEM_RDY=1 -> DECODE next cycle, O_PC_INC=1 that cycle.
REQ-019 DECODE -> REGREAD, REGREAD -> ALU, unconditionally, one cycle each.
REQ-020 ALU: I_IS_MEM=1 -> MEMORY; else I_IS_WB=1 -> REGWRITE; else -> FETCH (instruction retired).
REQ-021 MEMORY: O_MEM_REQ=1; I_MEM_RDY=1 -> REGWRITE if I_IS_WB else FETCH (retired).
REQ-022 REGWRITE: one cycle, -> FETCH (retired).
REQ-023 O_RF_EN SHALL be 1 in REGREAD and REGWRITE only; O_RF_WE 1 in REGWRITE only (register file samples on falling edge mid-cycle).
REQ-024 O_RF_EN, O_RF_WE, O_MEM_REQ, O_PC_INC SHALL be decoded combinationally from state and inputs; no extra latency.
REQ-025 Wait counter SHALL clear on entry to FETCH/MEMORY, count cycles with O_MEM_REQ=1 and I_MEM_RDY=0, hold while I_HALT=1.
REQ-026 Counter reaching MEM_TIMEOUT without ready: set O_ERR; in FETCH clear counter and retry; in MEMORY abort to FETCH, no write, no retire.
REQ-027 I_MEM_RDY=1 in the timeout cycle SHALL win: normal transition, O_ERR unchanged.
REQ-028 O_INSTR_CNT SHALL increment by 1 on each retire transition, wrap modulo 2^CNT_W; aborted instructions not counted.
REQ-029 O_ERR SHALL remain 1 until reset; FSM keeps operating.
REQ-030 I_MEM_RDY outside FETCH/MEMORY and I_HALT outside FETCH SHALL be ignored.

Reset
REQ-031 I_RST=1 at a rising edge SHALL force FETCH (O_STATE=6'b000001), wait counter 0, O_ERR=0, O_INSTR_CNT=0, from any state, mid-instruction included.
REQ-032 During reset O_RF_EN=0, O_RF_WE=0, O_PC_INC=0; O_MEM_REQ follows FETCH decode only after I_RST deasserts.
REQ-033 Reset SHALL take priority over every transition and counter update.

Structure
REQ-034 Package ctrl_pkg SHALL hold state encodings and bit indices, default MEM_TIMEOUT and CNT_W.
REQ-035 Wait counter with terminal-count flag SHALL be sub-module wait_timer; FSM and retire counter stay in ctrl_unit.

Verification
REQ-036 Reset then ready in FETCH, ALU with IS_MEM=0, IS_WB=1 -> FETCH,DECODE,REGREAD,ALU,REGWRITE,FETCH; RF_WE one cycle; INSTR_CNT=1.
REQ-037 IS_MEM=1, IS_WB=1, ready after 3 MEMORY cycles -> MEMORY held 4 cycles, then REGWRITE; INSTR_CNT+1; O_ERR=0.
REQ-038 MEMORY with ready never asserted, MEM_TIMEOUT=15 -> FETCH after 15 waiting cycles, O_ERR=1, no RF_WE, INSTR_CNT unchanged.
REQ-039 Ready on exactly the 15th wait cycle -> normal transition, O_ERR=0.
REQ-040 I_HALT=1 for 20 cycles in FETCH -> O_MEM_REQ=0, no O_ERR; release + ready -> DECODE, O_PC_INC pulse.
REQ-041 Preload INSTR_CNT to 0xFFFF via retires, retire once -> 0x0000; I_RST in ALU -> FETCH next cycle, all counters 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle control unit: one-hot state encodings,
// state bit positions and default parameter values.
package ctrl_pkg;

   localparam int DEF_MEM_TIMEOUT = 15;
   localparam int DEF_CNT_W       = 16;
   localparam int TIMER_W         = 8;
   localparam int STATE_W         = 6;

   localparam int BIT_FETCH    = 0;
   localparam int BIT_DECODE   = 1;
   localparam int BIT_REGREAD  = 2;
   localparam int BIT_ALU      = 3;
   localparam int BIT_MEMORY   = 4;
   localparam int BIT_REGWRITE = 5;

   localparam logic [STATE_W-1:0] ST_FETCH    = 6'b000001;
   localparam logic [STATE_W-1:0] ST_DECODE   = 6'b000010;
   localparam logic [STATE_W-1:0] ST_REGREAD  = 6'b000100;
   localparam logic [STATE_W-1:0] ST_ALU      = 6'b001000;
   localparam logic [STATE_W-1:0] ST_MEMORY   = 6'b010000;
   localparam logic [STATE_W-1:0] ST_REGWRITE = 6'b100000;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait counter: counts stalled request cycles and flags the cycle in
// which the LIMIT-th consecutive stall occurs.
module wait_timer
   import ctrl_pkg::*;
#(
   parameter int LIMIT = DEF_MEM_TIMEOUT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic count_i,
   output logic done_o
);

   localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

   logic [TIMER_W-1:0] cnt_q;
   logic [TIMER_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (count_i) begin
         cnt_d = cnt_q + TIMER_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The stall cycle that would make the count reach LIMIT is the timeout cycle.
   assign done_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/REGREAD/ALU/MEMORY/REGWRITE
// with memory timeout detection and a retired-instruction counter.
module ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic               I_CLK,
   input  logic               I_RST,
   input  logic               I_MEM_RDY,
   input  logic               I_IS_MEM,
   input  logic               I_IS_WB,
   input  logic               I_HALT,
   output logic [STATE_W-1:0] O_STATE,
   output logic               O_RF_EN,
   output logic               O_RF_WE,
   output logic               O_MEM_REQ,
   output logic               O_PC_INC,
   output logic               O_ERR,
   output logic [CNT_W-1:0]   O_INSTR_CNT
);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   logic               err_q;
   logic               err_d;
   logic [CNT_W-1:0]   instr_cnt_q;
   logic [CNT_W-1:0]   instr_cnt_d;

   logic inFetch;
   logic inMemory;
   logic memReq;
   logic memWait;
   logic timeout;
   logic retire;
   logic timerClear;

   assign inFetch  = state_q[BIT_FETCH];
   assign inMemory = state_q[BIT_MEMORY];

   // Strobes are gated by reset so nothing escapes while the state is being forced.
   assign memReq    = !I_RST && ((inFetch && !I_HALT) || inMemory);
   assign memWait   = memReq && !I_MEM_RDY;
   assign O_MEM_REQ = memReq;
   assign O_PC_INC  = !I_RST && inFetch && !I_HALT && I_MEM_RDY;
   assign O_RF_EN   = !I_RST && (state_q[BIT_REGREAD] || state_q[BIT_REGWRITE]);
   assign O_RF_WE   = !I_RST && state_q[BIT_REGWRITE];

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (!I_HALT && I_MEM_RDY) state_d = ST_DECODE;
         end
         ST_DECODE:  state_d = ST_REGREAD;
         ST_REGREAD: state_d = ST_ALU;
         ST_ALU: begin
            if (I_IS_MEM) begin
               state_d = ST_MEMORY;
            end else if (I_IS_WB) begin
               state_d = ST_REGWRITE;
            end else begin
               state_d = ST_FETCH;
               retire  = 1'b1;
            end
         end
         ST_MEMORY: begin
            if (I_MEM_RDY) begin
               if (I_IS_WB) begin
                  state_d = ST_REGWRITE;
               end else begin
                  state_d = ST_FETCH;
                  retire  = 1'b1;
               end
            end else if (timeout) begin
               state_d = ST_FETCH;
            end
         end
         ST_REGWRITE: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // Entering a new state or timing out in FETCH restarts the wait count.
   assign timerClear  = (state_d != state_q) || timeout;
   assign err_d       = err_q || timeout;
   assign instr_cnt_d = retire ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;

   wait_timer #(
      .LIMIT(MEM_TIMEOUT)
   ) u_wait_timer (
      .clk_i  (I_CLK),
      .rst_i  (I_RST),
      .clear_i(timerClear),
      .count_i(memWait),
      .done_o (timeout)
   );

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         state_q     <= ST_FETCH;
         err_q       <= 1'b0;
         instr_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign O_STATE     = state_q;
   assign O_ERR       = err_q;
   assign O_INSTR_CNT = instr_cnt_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed self-checking bench for ctrl_unit: instruction flows, memory
// timeouts, halt, counter wrap and mid-instruction reset.
module tb_ctrl_unit;

   localparam logic [5:0] S_FETCH    = 6'b000001;
   localparam logic [5:0] S_DECODE   = 6'b000010;
   localparam logic [5:0] S_REGREAD  = 6'b000100;
   localparam logic [5:0] S_ALU      = 6'b001000;
   localparam logic [5:0] S_MEMORY   = 6'b010000;
   localparam logic [5:0] S_REGWRITE = 6'b100000;

   logic       clk;
   logic       rst;
   logic       memRdy;
   logic       isMem;
   logic       isWb;
   logic       halt;
   logic [5:0] state;
   logic       rfEn;
   logic       rfWe;
   logic       memReq;
   logic       pcInc;
   logic       err;
   logic [7:0] instrCnt;

   int testCount = 0;
   int failCount = 0;

   ctrl_unit #(
      .MEM_TIMEOUT(15),
      .CNT_W      (8)
   ) dut (
      .I_CLK      (clk),
      .I_RST      (rst),
      .I_MEM_RDY  (memRdy),
      .I_IS_MEM   (isMem),
      .I_IS_WB    (isWb),
      .I_HALT     (halt),
      .O_STATE    (state),
      .O_RF_EN    (rfEn),
      .O_RF_WE    (rfWe),
      .O_MEM_REQ  (memReq),
      .O_PC_INC   (pcInc),
      .O_ERR      (err),
      .O_INSTR_CNT(instrCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      testCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic rdy, input logic m, input logic wb, input logic h);
      rst    = r;
      memRdy = rdy;
      isMem  = m;
      isWb   = wb;
      halt   = h;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Walks FETCH (ready at once) -> DECODE -> REGREAD, leaving the DUT in ALU.
   task automatic runToAlu(input bit chk);
      applyStimulus(0, 1, 0, 0, 0);
      if (chk) begin
         checkOutput("fetch_state", 16'(state), 16'(S_FETCH));
         checkOutput("fetch_pcinc", 16'(pcInc), 16'd1);
      end
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      if (chk) begin
         checkOutput("decode_state", 16'(state), 16'(S_DECODE));
         checkOutput("decode_rfen", 16'(rfEn), 16'd0);
      end
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      if (chk) begin
         checkOutput("regread_state", 16'(state), 16'(S_REGREAD));
         checkOutput("regread_rfen", 16'(rfEn), 16'd1);
         checkOutput("regread_rfwe", 16'(rfWe), 16'd0);
      end
      nextCycle();
   endtask

   task automatic doReset();
      applyStimulus(1, 0, 0, 0, 0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("rst_state", 16'(state), 16'(S_FETCH));
      checkOutput("rst_err", 16'(err), 16'd0);
      checkOutput("rst_cnt", 16'(instrCnt), 16'd0);
   endtask

   task automatic fetchTimeout();
      for (int i = 0; i < 15; i++) begin
         applyStimulus(0, 0, 0, 0, 0);
         checkOutput("fto_state", 16'(state), 16'(S_FETCH));
         checkOutput("fto_memreq", 16'(memReq), 16'd1);
         nextCycle();
      end
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("fto_err", 16'(err), 16'd1);
      checkOutput("fto_stay", 16'(state), 16'(S_FETCH));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      applyStimulus(1, 1, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_state", 16'(state), 16'(S_FETCH));
      checkOutput("reset_memreq", 16'(memReq), 16'd0);
      checkOutput("reset_pcinc", 16'(pcInc), 16'd0);
      checkOutput("reset_rfen", 16'(rfEn), 16'd0);
      checkOutput("reset_err", 16'(err), 16'd0);
      checkOutput("reset_cnt", 16'(instrCnt), 16'd0);
      nextCycle();

      // ALU with write-back: FETCH, DECODE, REGREAD, ALU, REGWRITE, FETCH.
      runToAlu(1);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("wb_alu_state", 16'(state), 16'(S_ALU));
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("wb_regwrite_state", 16'(state), 16'(S_REGWRITE));
      checkOutput("wb_rfwe", 16'(rfWe), 16'd1);
      checkOutput("wb_rfen", 16'(rfEn), 16'd1);
      nextCycle();
      checkOutput("wb_fetch_state", 16'(state), 16'(S_FETCH));
      checkOutput("wb_rfwe_off", 16'(rfWe), 16'd0);
      checkOutput("wb_cnt", 16'(instrCnt), 16'd1);

      // Memory access ready after three stalled cycles.
      runToAlu(1);
      applyStimulus(0, 0, 1, 1, 0);
      nextCycle();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 1, 1, 0);
         checkOutput("mem_wait_state", 16'(state), 16'(S_MEMORY));
         checkOutput("mem_wait_req", 16'(memReq), 16'd1);
         nextCycle();
      end
      applyStimulus(0, 1, 1, 1, 0);
      checkOutput("mem_ready_state", 16'(state), 16'(S_MEMORY));
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("mem_regwrite", 16'(state), 16'(S_REGWRITE));
      checkOutput("mem_rfwe", 16'(rfWe), 16'd1);
      nextCycle();
      checkOutput("mem_cnt", 16'(instrCnt), 16'd2);
      checkOutput("mem_err", 16'(err), 16'd0);

      // Memory never ready: abort to FETCH after 15 stalled cycles.
      runToAlu(1);
      applyStimulus(0, 0, 1, 1, 0);
      nextCycle();
      for (int i = 0; i < 15; i++) begin
         applyStimulus(0, 0, 1, 1, 0);
         checkOutput("mto_state", 16'(state), 16'(S_MEMORY));
         checkOutput("mto_rfwe", 16'(rfWe), 16'd0);
         checkOutput("mto_err_pending", 16'(err), 16'd0);
         nextCycle();
      end
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("mto_abort_state", 16'(state), 16'(S_FETCH));
      checkOutput("mto_err", 16'(err), 16'd1);
      checkOutput("mto_cnt", 16'(instrCnt), 16'd2);

      doReset();

      // Ready arrives on the 15th stalled cycle: no timeout.
      runToAlu(1);
      applyStimulus(0, 0, 1, 0, 0);
      nextCycle();
      for (int i = 0; i < 14; i++) begin
         applyStimulus(0, 0, 1, 0, 0);
         checkOutput("edge_state", 16'(state), 16'(S_MEMORY));
         nextCycle();
      end
      applyStimulus(0, 1, 1, 0, 0);
      checkOutput("edge_last_state", 16'(state), 16'(S_MEMORY));
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("edge_fetch", 16'(state), 16'(S_FETCH));
      checkOutput("edge_err", 16'(err), 16'd0);
      checkOutput("edge_cnt", 16'(instrCnt), 16'd1);

      // Halt for 20 cycles, ready toggling underneath.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, (i >= 10), 0, 0, 1);
         checkOutput("halt_state", 16'(state), 16'(S_FETCH));
         checkOutput("halt_memreq", 16'(memReq), 16'd0);
         checkOutput("halt_pcinc", 16'(pcInc), 16'd0);
         nextCycle();
      end
      checkOutput("halt_err", 16'(err), 16'd0);
      runToAlu(1);
      applyStimulus(0, 0, 0, 0, 0);
      nextCycle();
      checkOutput("halt_retire_cnt", 16'(instrCnt), 16'd2);

      // FETCH timeout: flag set, keep requesting, then proceed normally.
      fetchTimeout();
      checkOutput("fto_retry_memreq", 16'(memReq), 16'd1);
      runToAlu(1);
      applyStimulus(0, 0, 0, 0, 0);
      nextCycle();
      checkOutput("fto_retire_cnt", 16'(instrCnt), 16'd3);
      checkOutput("fto_err_sticky", 16'(err), 16'd1);

      doReset();

      // Counter wrap: 255 retires, then one more.
      for (int i = 0; i < 255; i++) begin
         runToAlu(0);
         applyStimulus(0, 0, 0, 0, 0);
         nextCycle();
      end
      checkOutput("wrap_full", 16'(instrCnt), 16'h00FF);
      runToAlu(0);
      applyStimulus(0, 0, 0, 0, 0);
      nextCycle();
      checkOutput("wrap_zero", 16'(instrCnt), 16'h0000);
      runToAlu(0);
      applyStimulus(0, 0, 0, 0, 0);
      nextCycle();
      checkOutput("wrap_one", 16'(instrCnt), 16'h0001);

      // Reset in ALU with nonzero count and error set.
      fetchTimeout();
      runToAlu(1);
      applyStimulus(1, 0, 1, 1, 0);
      checkOutput("alu_rst_state", 16'(state), 16'(S_ALU));
      nextCycle();
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("alu_rst_fetch", 16'(state), 16'(S_FETCH));
      checkOutput("alu_rst_cnt", 16'(instrCnt), 16'd0);
      checkOutput("alu_rst_err", 16'(err), 16'd0);
      checkOutput("alu_rst_memreq", 16'(memReq), 16'd0);
      checkOutput("alu_rst_pcinc", 16'(pcInc), 16'd0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("alu_rel_memreq", 16'(memReq), 16'd1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
